tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte sources. It selects a requester, appends the parity bit, pulses the transmitter's `enable`, generates the transmitter's `baud_clk` tick, and tracks `o_busy` until the frame completes before granting again. It sits between the byte producers and the UART Tx datapath, whose `enable`, `i_data`, `baud_clk` and `o_busy` ports it drives and monitors directly.

---
 rtl/tx_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources
module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_ODD   = 0,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          tx_enable,
  output logic [DATA_WIDTH:0]           tx_data,
  output logic                          baud_clk,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          ctrl_busy,
  output logic [15:0]                   frame_count
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d, grant_q, grant_d, win, idx;
  logic [DATA_WIDTH:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0] win_byte;
  logic [CW-1:0]         baud_q, baud_d;
  logic [1:0]            tmo_q, tmo_d;
  logic [15:0]           count_q, count_d;
  logic                  counting;
  // Descending scan so the valid index closest to rr_ptr is assigned last and wins
  always_comb begin
    win      = '0;
    idx      = '0;
    win_byte = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (win == PW'(i)) win_byte = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign counting = state_q == WAIT_BUSY || state_q == WAIT_DONE;
  assign baud_clk = counting && baud_q == CW'(CLKS_PER_BIT - 1);
  assign baud_d   = !counting ? '0 : baud_clk ? '0 : baud_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    count_d  = count_q;
    case (state_q)
      IDLE:
        if (|req_valid && !tx_busy) begin
          state_d  = LOAD;
          grant_d  = win;
          rr_ptr_d = win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
          data_d   = {^win_byte ^ 1'(PARITY_ODD), win_byte};
        end
      LOAD: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY:
        if (tx_busy) state_d = WAIT_DONE;
        else if (tmo_q == 2'd3) state_d = IDLE;
        else tmo_d = tmo_q + 1'b1;
      WAIT_DONE:
        if (!tx_busy) begin
          state_d = IDLE;
          count_d = count_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      baud_q   <= '0;
      tmo_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      baud_q   <= baud_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
    end
  assign tx_enable   = state_q == LOAD;
  assign req_ack     = tx_enable ? NUM_REQ'(1) << grant_q : '0;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign ctrl_busy   = state_q != IDLE;
  assign frame_count = count_q;
endmodule
